// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with skid buffer, redirect and IF/ID register

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        pc_write,
  input  logic        if_id_write,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // FETCH: may issue; WAIT: one request outstanding; DROP: outstanding response is stale
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;

  logic [31:0] redirect_target;
  logic        handshake;

  // Low address bits are dropped so every fetch address is word aligned
  assign redirect_target = redirect_pc & ~32'h0000_0003;

  // Issue only when idle, the skid buffer is free, the hazard unit allows it and no redirect
  assign imem_req_valid = reset_n && (state_q == ST_FETCH) && !buf_valid_q
                          && pc_write && !redirect_valid;
  assign handshake      = imem_req_valid && imem_req_ready;

  assign imem_req_addr = pc_q;
  assign if_id_valid   = if_id_valid_q;
  assign if_id_pc      = if_id_pc_q;
  assign if_id_instr   = if_id_instr_q;

  // Next-state: redirect first, then issue, response capture and IF/ID advance
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    buf_valid_d   = buf_valid_q;
    buf_pc_d      = buf_pc_q;
    buf_instr_d   = buf_instr_q;
    if_id_valid_d = if_id_valid_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;

    if (redirect_valid) begin
      pc_d          = redirect_target;
      if_id_valid_d = 1'b0;
      buf_valid_d   = 1'b0;
      case (state_q)
        // A response landing with the redirect closes the request, so no DROP needed
        ST_WAIT:  state_d = imem_resp_valid ? ST_FETCH : ST_DROP;
        // The stale response still retires the outstanding request
        ST_DROP:  state_d = imem_resp_valid ? ST_FETCH : ST_DROP;
        default:  state_d = ST_FETCH;
      endcase
    end else begin
      if (handshake) begin
        req_pc_d = pc_q;
        pc_d     = pc_q + 32'd4;
        state_d  = ST_WAIT;
      end

      case (state_q)
        ST_WAIT: begin
          if (imem_resp_valid) begin
            state_d = ST_FETCH;
            if (if_id_write) begin
              if_id_valid_d = 1'b1;
              if_id_pc_d    = req_pc_q;
              if_id_instr_d = imem_resp_data;
            end else begin
              buf_valid_d = 1'b1;
              buf_pc_d    = req_pc_q;
              buf_instr_d = imem_resp_data;
            end
          end
        end
        ST_DROP: begin
          if (imem_resp_valid) begin
            state_d = ST_FETCH;
          end
        end
        default: ;
      endcase

      // Advance IF/ID from the buffer, or insert a bubble, when no response was taken
      if (if_id_write && !(state_q == ST_WAIT && imem_resp_valid)) begin
        if (buf_valid_q) begin
          if_id_valid_d = 1'b1;
          if_id_pc_d    = buf_pc_q;
          if_id_instr_d = buf_instr_q;
          buf_valid_d   = 1'b0;
        end else begin
          if_id_valid_d = 1'b0;
        end
      end
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= ST_FETCH;
      pc_q          <= RESET_PC;
      req_pc_q      <= 32'h0;
      buf_valid_q   <= 1'b0;
      buf_pc_q      <= 32'h0;
      buf_instr_q   <= 32'h0;
      if_id_valid_q <= 1'b0;
      if_id_pc_q    <= 32'h0;
      if_id_instr_q <= NOP_INSTR;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      buf_valid_q   <= buf_valid_d;
      buf_pc_q      <= buf_pc_d;
      buf_instr_q   <= buf_instr_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage

module tb_fetch_stage;

  logic        clock;
  logic        reset_n;
  logic        pc_write;
  logic        if_id_write;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] INSTR_A = 32'h0010_0093;
  localparam logic [31:0] INSTR_B = 32'h0020_0113;
  localparam logic [31:0] INSTR_C = 32'h0030_0193;
  localparam logic [31:0] INSTR_D = 32'h0040_0213;
  localparam logic [31:0] INSTR_E = 32'h0050_0293;
  localparam logic [31:0] INSTR_F = 32'h0060_0313;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  fetch_stage dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .if_id_valid     (if_id_valid),
    .if_id_pc        (if_id_pc),
    .if_id_instr     (if_id_instr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n         = 1'b0;
    pc_write        = 1'b1;
    if_id_write     = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    tick();
    tick();
    reset_n = 1'b1;
    settle();
  endtask

  initial begin
    // ---- reset state and basic stream ----
    reset_n         = 1'b0;
    pc_write        = 1'b1;
    if_id_write     = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    tick();
    tick();
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_addr", imem_req_addr, 32'h0);
    chk("rst_ifid_valid", {31'b0, if_id_valid}, 32'd0);
    chk("rst_ifid_pc", if_id_pc, 32'h0);
    chk("rst_ifid_instr", if_id_instr, NOP);

    reset_n = 1'b1;
    settle();
    chk("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("first_req_addr", imem_req_addr, 32'h0);
    tick();                                   // handshake 0x0
    imem_resp_valid = 1'b1; imem_resp_data = INSTR_A;
    settle();
    chk("wait_no_req", {31'b0, imem_req_valid}, 32'd0);
    tick();                                   // A returns
    imem_resp_valid = 1'b0;
    settle();
    chk("a_valid", {31'b0, if_id_valid}, 32'd1);
    chk("a_pc", if_id_pc, 32'h0);
    chk("a_instr", if_id_instr, INSTR_A);
    chk("req4_addr", imem_req_addr, 32'h4);
    tick();                                   // handshake 0x4, bubble
    chk("bubble_valid", {31'b0, if_id_valid}, 32'd0);
    imem_resp_valid = 1'b1; imem_resp_data = INSTR_B;
    tick();
    imem_resp_valid = 1'b0;
    settle();
    chk("b_pc", if_id_pc, 32'h4);
    chk("b_instr", if_id_instr, INSTR_B);
    chk("req8_addr", imem_req_addr, 32'h8);
    tick();                                   // handshake 0x8
    imem_resp_valid = 1'b1; imem_resp_data = INSTR_C;
    tick();
    imem_resp_valid = 1'b0;
    settle();
    chk("c_valid", {31'b0, if_id_valid}, 32'd1);
    chk("c_pc", if_id_pc, 32'h8);
    chk("c_instr", if_id_instr, INSTR_C);

    // ---- stall with skid buffer capture ----
    do_reset();
    tick();                                   // handshake 0x0
    imem_resp_valid = 1'b1; imem_resp_data = INSTR_A;
    tick();                                   // IF/ID = (0,A)
    imem_resp_valid = 1'b0;
    if_id_write = 1'b0;                       // issue 0x4 while IF/ID holds
    tick();
    pc_write = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = INSTR_B;
    tick();                                   // B goes to skid buffer
    imem_resp_valid = 1'b0;
    settle();
    chk("stall_hold_valid", {31'b0, if_id_valid}, 32'd1);
    chk("stall_hold_pc", if_id_pc, 32'h0);
    chk("stall_no_req", {31'b0, imem_req_valid}, 32'd0);
    tick();                                   // second stall cycle
    chk("stall2_hold_pc", if_id_pc, 32'h0);
    if_id_write = 1'b1; pc_write = 1'b1;
    settle();
    chk("buf_blocks_req", {31'b0, imem_req_valid}, 32'd0);
    tick();                                   // buffer drains into IF/ID
    chk("drain_valid", {31'b0, if_id_valid}, 32'd1);
    chk("drain_pc", if_id_pc, 32'h4);
    chk("drain_instr", if_id_instr, INSTR_B);
    chk("resume_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("resume_addr", imem_req_addr, 32'h8);

    // ---- redirect while waiting ----
    if_id_write = 1'b0;
    tick();                                   // handshake 0x8, IF/ID held
    if_id_write = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    settle();
    chk("redir_no_req", {31'b0, imem_req_valid}, 32'd0);
    tick();                                   // WAIT -> DROP
    redirect_valid = 1'b0;
    settle();
    chk("redir_kill_valid", {31'b0, if_id_valid}, 32'd0);
    chk("redir_addr", imem_req_addr, 32'h100);
    chk("drop_no_req", {31'b0, imem_req_valid}, 32'd0);
    imem_resp_valid = 1'b1; imem_resp_data = INSTR_C;
    tick();                                   // stale 0x8 response dropped
    imem_resp_valid = 1'b0;
    settle();
    chk("drop_ifid_valid", {31'b0, if_id_valid}, 32'd0);
    chk("drop_ifid_pc", if_id_pc, 32'h4);
    chk("after_drop_req", {31'b0, imem_req_valid}, 32'd1);
    chk("after_drop_addr", imem_req_addr, 32'h100);

    // ---- redirect coincident with response ----
    tick();                                   // handshake 0x100
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    imem_resp_valid = 1'b1; imem_resp_data = INSTR_D;
    tick();
    redirect_valid = 1'b0; imem_resp_valid = 1'b0;
    settle();
    chk("coinc_ifid_valid", {31'b0, if_id_valid}, 32'd0);
    chk("coinc_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("coinc_addr", imem_req_addr, 32'h200);

    // ---- pc wrap ----
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    settle();
    chk("fetch_redir_no_req", {31'b0, imem_req_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    settle();
    chk("wrap_top_addr", imem_req_addr, 32'hFFFF_FFFC);
    tick();                                   // handshake 0xFFFFFFFC
    chk("wrap_pc", imem_req_addr, 32'h0);
    imem_resp_valid = 1'b1; imem_resp_data = INSTR_E;
    tick();
    imem_resp_valid = 1'b0;
    settle();
    chk("wrap_ifid_pc", if_id_pc, 32'hFFFF_FFFC);
    chk("wrap_ifid_instr", if_id_instr, INSTR_E);
    chk("wrap_next_req", {31'b0, imem_req_valid}, 32'd1);

    // ---- reset while waiting, late response ----
    tick();                                   // handshake 0x0, now WAIT
    reset_n = 1'b0;
    settle();
    chk("mid_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    tick();
    reset_n = 1'b1;
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = INSTR_F;
    settle();
    chk("post_rst_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("post_rst_addr", imem_req_addr, 32'h0);
    tick();                                   // late response ignored
    imem_resp_valid = 1'b0;
    settle();
    chk("late_ifid_valid", {31'b0, if_id_valid}, 32'd0);
    chk("late_ifid_instr", if_id_instr, NOP);
    chk("late_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("late_addr", imem_req_addr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the fetch address after reset.
REQ-002 The block SHALL have a single clock port `clock`, input, 1 bit; all state updates on its rising edge.
REQ-003 The block SHALL have `reset_n`, input, 1 bit, the reset; it is synchronous and active-low.
REQ-004 The block SHALL have `pc_write`, input, 1 bit; from the hazard unit; 0 blocks issue of new fetch requests.
REQ-005 The block SHALL have `if_id_write`, input, 1 bit; from the hazard unit; 0 holds the IF/ID register.
REQ-006 The block SHALL have `redirect_valid`, input, 1 bit: taken branch/jump from EX.
REQ-007 The block SHALL have `redirect_pc`, input, 32 bits: the redirect target.
REQ-008 The block SHALL have `imem_req_valid`, output, 1 bit: fetch request.
REQ-009 The block SHALL have `imem_req_addr`, output, 32 bits: word-aligned fetch address.
REQ-010 The block SHALL have `imem_req_ready`, input, 1 bit: memory accepts the request.
REQ-011 The block SHALL have `imem_resp_valid`, input, 1 bit, and `imem_resp_data`, input, 32 bits: instruction return, one response per accepted request, at least 1 cycle after acceptance.
REQ-012 The block SHALL have `if_id_valid`, output, 1 bit, plus `if_id_pc`, output, 32 bits, and `if_id_instr`, output, 32 bits: the IF/ID pipeline register contents.

Function
REQ-013 The block SHALL hold these registers: pc, req_pc, a one-entry skid buffer (buf_valid, buf_pc, buf_instr), the IF/ID register, and a state machine with states FETCH, WAIT and DROP.
REQ-014 The block SHALL drive imem_req_valid = (state==FETCH) && !buf_valid && pc_write && !redirect_valid, combinationally.
REQ-015 The block SHALL drive imem_req_addr = pc, always.
REQ-016 A handshake SHALL occur when imem_req_valid && imem_req_ready; on it: req_pc <= pc; pc <= pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000); FETCH->WAIT.
REQ-017 At most one request SHALL be outstanding.
REQ-018 In WAIT, on imem_resp_valid, the block SHALL go to FETCH.
  - If if_id_write=1: the IF/ID register loads {1, req_pc, imem_resp_data}.
  - Otherwise: the skid buffer loads {1, req_pc, imem_resp_data}.
REQ-019 When if_id_write=1, with no redirect and no response consumed that cycle, the IF/ID register SHALL load from the skid buffer if buf_valid, clearing buf_valid; otherwise it loads a bubble (if_id_valid=0, pc/instr held).
REQ-020 When if_id_write=0, with no redirect, the IF/ID register SHALL hold all fields.
REQ-021 A response arriving in WAIT SHALL find the buffer empty, since issue requires !buf_valid; the buffer and a response are never both pending.
REQ-022 redirect_valid=1 SHALL take highest priority, overriding pc_write and if_id_write.
  - pc <= {redirect_pc[31:2], 2'b00}.
  - if_id_valid <= 0; buf_valid <= 0.
  - WAIT->DROP; FETCH and DROP stay in place.
  - No request is issued that cycle.
REQ-023 In DROP, imem_resp_valid SHALL discard the response and return the FSM to FETCH; IF/ID and the buffer are unchanged by that response.
REQ-024 A redirect arriving in DROP SHALL update pc and remain in DROP.
REQ-025 If redirect_valid and imem_resp_valid coincide in WAIT, the response SHALL be discarded and the FSM SHALL go to FETCH, not DROP.
REQ-026 imem_resp_valid asserted in FETCH SHALL be ignored.
REQ-027 imem_req_valid SHALL be the only combinational output; all other outputs are registered.

Reset
REQ-028 While reset_n=0 at a clock edge:
  - pc <= RESET_PC; req_pc <= 0; state <= FETCH.
  - buf_valid <= 0; buf_pc and buf_instr <= 0.
  - if_id_valid <= 0; if_id_pc <= 0; if_id_instr <= 32'h0000_0013 (NOP).
REQ-029 During reset, imem_req_valid SHALL be 0.
REQ-030 Reset mid-transaction SHALL abandon any outstanding request; a late response then arrives in FETCH and is ignored under REQ-026.
REQ-031 The first request SHALL be able to issue in the first cycle with reset_n=1.

Verification
REQ-032 Reset release with ready=1 and 1-cycle response latency, instrs A,B,C -> requests to 0x0,0x4,0x8; IF/ID shows (0x0,A),(0x4,B),(0x8,C), each valid; a bubble appears between instructions because of the WAIT cycle.
REQ-033 Stall: if_id_write=0, pc_write=0 for 2 cycles while instr at 0x4 returns -> IF/ID holds 0x0; the buffer captures 0x4; no new request; on release IF/ID shows 0x4, then fetch of 0x8 resumes.
REQ-034 Redirect to 0x103 while in WAIT for 0x8 -> IF/ID valid=0; the 0x8 response is dropped; next request address is 0x100.
REQ-035 Redirect coincident with a response -> the response is discarded and the next request goes directly to the target.
REQ-036 redirect_pc=0xFFFF_FFFC followed by a handshake -> pc wraps to 0x0; the next request address is 0x0.
REQ-037 reset_n=0 asserted in WAIT, late response on the cycle after release -> IF/ID remains invalid with NOP; the first request is at RESET_PC.
